// File: rtl/mod_n_counter_ctl.sv
// mod_n_counter_ctl: programmable modulo-N counter with run-control FSM.
//
// Counts 0..M-1 (M = N, or 2^WIDTH when N == 0) up or down, in periodic
// (auto-wrap) or one-shot mode. TC flags the terminal count while running,
// and ceo = ce & TC feeds the ce input of the next cascade stage.
//
// Optional feature: define MOD_N_COUNTER_SQW_EN to add the sqw output, a
// registered square wave that toggles on every cascade-enable pulse and
// gives a 50% duty cycle with a period of 2*M enabled steps.

module mod_n_counter_ctl #(
    parameter int               WIDTH   = 11,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] N,
    input  logic             up,
    input  logic             mode,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             TC,
    output logic             ceo,
    output logic             busy,
`ifdef MOD_N_COUNTER_SQW_EN
    output logic             done,
    output logic             sqw
`else
    output logic             done
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_mod_m1;
    logic [WIDTH-1:0] w_init;
    logic [WIDTH-1:0] w_term;
    logic             w_term_hit;
    logic             w_step;
    logic             w_tc;
    logic             w_ceo;

    // M-1 in WIDTH-bit arithmetic; N == 0 wraps to all ones, which is 2^WIDTH-1.
    assign w_mod_m1 = N - ONE;

    // Restart value: bottom of range when counting up, top when counting down.
    assign w_init = up ? '0 : w_mod_m1;

    // Value held once a one-shot run finishes.
    assign w_term = up ? w_mod_m1 : '0;

    // Counting up, anything at or above M-1 is terminal so that shrinking N
    // below the current count still wraps instead of running off to 2^WIDTH.
    assign w_term_hit = up ? (r_q >= w_mod_m1) : (r_q == '0);

    // A count step is only taken while running with the enable high.
    assign w_step = (r_state == ST_RUN) && ce;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop in
            // the design samples the pre-edge values, whatever the block order.
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start beats load, which beats the count step.
    always_comb begin
        // NOTE: defaulting every combinational output first keeps any branch
        // that forgets to assign it from inferring a latch.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!start && !load && ce && w_term_hit && mode) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status and cascade outputs, decoded from the state and current count.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        w_tc = 1'b0;
        case (r_state)
            ST_RUN: begin
                busy = 1'b1;
                w_tc = w_term_hit;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        w_ceo = w_tc & ce;
    end

    assign TC  = w_tc;
    assign ceo = w_ceo;
    assign q   = r_q;

    // Next count value: restart, load, then wrap / hold / step.
    always_comb begin
        w_q_nxt = r_q;
        if (start) begin
            w_q_nxt = w_init;
        end else if (load) begin
            w_q_nxt = din;
        end else if (w_step) begin
            if (w_term_hit) begin
                w_q_nxt = mode ? w_term : w_init;
            end else begin
                w_q_nxt = up ? (r_q + ONE) : (r_q - ONE);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= w_q_nxt;
        end
    end

`ifdef MOD_N_COUNTER_SQW_EN
    logic r_sqw;

    // Square-wave divider: toggles per cascade pulse, cleared by start only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sqw <= 1'b0;
        end else if (start) begin
            r_sqw <= 1'b0;
        end else if (w_ceo) begin
            r_sqw <= ~r_sqw;
        end
    end

    assign sqw = r_sqw;
`endif

endmodule

// File: tb/tb_mod_n_counter_ctl.sv
// Scoreboard bench for mod_n_counter_ctl: the stimulus process pushes the
// hand-computed response expected after each clk edge, and a monitor pops
// and compares it just after that edge. A second 4-bit instance covers the
// full-range (N = 0) case.

module tb_mod_n_counter_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 11-bit instance
    logic        ce, up, mode, start, load;
    logic [10:0] n, din;
    logic [10:0] q;
    logic        tc, ceo, busy, done;

    // 4-bit instance
    logic        ce4, up4, mode4, start4, load4;
    logic [3:0]  n4, din4;
    logic [3:0]  q4;
    logic        tc4, ceo4, busy4, done4;

`ifdef MOD_N_COUNTER_SQW_EN
    logic sqw, sqw4;
`endif

    mod_n_counter_ctl #(.WIDTH(11)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .N     (n),
        .up    (up),
        .mode  (mode),
        .start (start),
        .load  (load),
        .din   (din),
        .q     (q),
        .TC    (tc),
        .ceo   (ceo),
        .busy  (busy),
`ifdef MOD_N_COUNTER_SQW_EN
        .done  (done),
        .sqw   (sqw)
`else
        .done  (done)
`endif
    );

    mod_n_counter_ctl #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce4),
        .N     (n4),
        .up    (up4),
        .mode  (mode4),
        .start (start4),
        .load  (load4),
        .din   (din4),
        .q     (q4),
        .TC    (tc4),
        .ceo   (ceo4),
        .busy  (busy4),
`ifdef MOD_N_COUNTER_SQW_EN
        .done  (done4),
        .sqw   (sqw4)
`else
        .done  (done4)
`endif
    );

    typedef struct {
        int          cyc;
        string       name;
        bit          w4;
        logic [10:0] q;
        logic        tc;
        logic        ceo;
        logic        busy;
        logic        done;
        bit          chk_sqw;
        logic        sqw;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Queue the response expected right after the coming clk edge.
    task automatic exp_push(input string nm, input logic [10:0] eq, input logic etc,
                            input logic eceo, input logic ebusy, input logic edone,
                            input bit w4 = 1'b0, input bit cs = 1'b0, input logic es = 1'b0);
        exp_t e;
        e.cyc     = cyc + 1;
        e.name    = nm;
        e.w4      = w4;
        e.q       = eq;
        e.tc      = etc;
        e.ceo     = eceo;
        e.busy    = ebusy;
        e.done    = edone;
        e.chk_sqw = cs;
        e.sqw     = es;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: compare queued expectations 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc != cyc) begin
                    check({e.name, " stale cycle"}, 32'(cyc), 32'(e.cyc));
                end else if (e.w4) begin
                    check({e.name, " q"},    32'(q4),    32'(e.q));
                    check({e.name, " TC"},   32'(tc4),   32'(e.tc));
                    check({e.name, " ceo"},  32'(ceo4),  32'(e.ceo));
                    check({e.name, " busy"}, 32'(busy4), 32'(e.busy));
                    check({e.name, " done"}, 32'(done4), 32'(e.done));
                end else begin
                    check({e.name, " q"},    32'(q),    32'(e.q));
                    check({e.name, " TC"},   32'(tc),   32'(e.tc));
                    check({e.name, " ceo"},  32'(ceo),  32'(e.ceo));
                    check({e.name, " busy"}, 32'(busy), 32'(e.busy));
                    check({e.name, " done"}, 32'(done), 32'(e.done));
`ifdef MOD_N_COUNTER_SQW_EN
                    if (e.chk_sqw) begin
                        check({e.name, " sqw"}, 32'(sqw), 32'(e.sqw));
                    end
`endif
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int   steps;
        logic ce_v;
        logic [10:0] qe;

        rst_n = 1'b0;
        ce = 1'b0; up = 1'b1; mode = 1'b0; start = 1'b0; load = 1'b0;
        n = 11'd20; din = '0;
        ce4 = 1'b0; up4 = 1'b1; mode4 = 1'b0; start4 = 1'b0; load4 = 1'b0;
        n4 = 4'd0; din4 = '0;
        tick();
        tick();

        // Reset state
        check("reset q",    32'(q),    32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset TC",   32'(tc),   32'd0);
        check("reset ceo",  32'(ceo),  32'd0);
        rst_n = 1'b1;

        // Idle: ce alone does nothing
        ce = 1'b1;
        exp_push("idle hold", 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Periodic count N=20: 0..19, wrap, then on to 12
        start = 1'b1;
        exp_push("per start", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            exp_push("per count", 11'(k), k == 19, k == 19, 1'b1, 1'b0);
            tick();
        end
        exp_push("per wrap", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 12; k++) begin
            exp_push("per count2", 11'(k), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end

        // Async reset between edges at q=12
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst q",    32'(q),    32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst TC",   32'(tc),   32'd0);
        check("async rst ceo",  32'(ceo),  32'd0);
`ifdef MOD_N_COUNTER_SQW_EN
        check("async rst sqw",  32'(sqw),  32'd0);
`endif
        tick();
        rst_n = 1'b1;
        exp_push("post rst idle", 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Gated cascade: ce high every other clk
        ce = 1'b0;
        start = 1'b1;
        exp_push("casc start", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        steps = 0;
        for (int k = 0; k < 80; k++) begin
            ce_v = (k % 2 == 0);
            ce = ce_v;
            if (ce_v) steps++;
            qe = 11'(steps % 20);
            exp_push("cascade", qe, qe == 11'd19, (qe == 11'd19) && ce_v, 1'b1, 1'b0);
            tick();
        end

        // One-shot down, N=5
        n = 11'd5; up = 1'b0; mode = 1'b1; ce = 1'b1;
        start = 1'b1;
        exp_push("os start", 11'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        exp_push("os 3", 11'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        exp_push("os 2", 11'd2, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        exp_push("os 1", 11'd1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        exp_push("os 0", 11'd0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        exp_push("os done", 11'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        exp_push("os done hold", 11'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        start = 1'b1;
        exp_push("os restart", 11'd4, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        start = 1'b0;
        exp_push("os restart 3", 11'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick();

        // Load and priority, N=20 up periodic
        n = 11'd20; up = 1'b1; mode = 1'b0; ce = 1'b1;
        start = 1'b1;
        exp_push("ld start", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp_push("ld count", 11'(k), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        load = 1'b1; din = 11'd18;
        exp_push("load 18", 11'd18, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        load = 1'b0;
        exp_push("ld 19", 11'd19, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        exp_push("ld wrap", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        exp_push("ld 1", 11'd1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        start = 1'b1; load = 1'b1; din = 11'd9;
        exp_push("start beats load", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        start = 1'b0; ce = 1'b0; din = 11'd15;
        exp_push("load no ce", 11'd15, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        load = 1'b0; n = 11'd10;
        exp_push("N shrink TC", 11'd15, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        ce = 1'b1;
        exp_push("N shrink wrap", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();

        // Full range on the 4-bit instance, N=0 -> M=16
        ce4 = 1'b1; n4 = 4'd0; up4 = 1'b1; mode4 = 1'b0;
        start4 = 1'b1;
        exp_push("w4 start", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        start4 = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            exp_push("w4 count", 11'(k), k == 15, k == 15, 1'b1, 1'b0, 1'b1);
            tick();
        end
        exp_push("w4 wrap", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();

`ifdef MOD_N_COUNTER_SQW_EN
        // Square wave, N=3: sqw toggles every 3 enabled steps
        n = 11'd3; up = 1'b1; mode = 1'b0; ce = 1'b1;
        start = 1'b1;
        exp_push("sqw start", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp_push("sqw run", 11'(k % 3), (k % 3) == 2, (k % 3) == 2, 1'b1, 1'b0,
                     1'b0, 1'b1, ((k / 3) % 2) == 1);
            tick();
        end
        start = 1'b1;
        exp_push("sqw start clr", 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        start = 1'b0;
`endif

        // Drain and make sure every expectation was consumed
        tick();
        tick();
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_n_counter_ctl.md
Name: mod_n_counter_ctl

Overview:
- Parametrised successor to the team's fixed-width modulo-N counter with clock-enable cascade outputs (q, TC, ceo).
- Adds generic width, up/down direction, synchronous load, and periodic or one-shot operation under a small run-control FSM.
- Used as a programmable timebase, divider or cascade stage; ceo drives ce of the next stage.

Parameters:
WIDTH, 11, counter, modulus and load-data width
RST_VAL, 0, value of q after reset (WIDTH bits)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ce  input  1  count enable; one step per clk edge with ce=1
N  input  WIDTH  modulus; N=0 means 2^WIDTH
up  input  1  1 = count up, 0 = count down
mode  input  1  0 = periodic (auto-wrap), 1 = one-shot
start  input  1  synchronous start/restart pulse
load  input  1  synchronous load of din into q
din  input  WIDTH  load value
q  output  WIDTH  current count (registered)
TC  output  1  terminal count, combinational
ceo  output  1  ce & TC, cascade enable
busy  output  1  FSM in RUN
done  output  1  FSM in DONE (one-shot finished)

Behaviour:
- One clock (clk), reset asynchronous and active-low (rst_n).
- Reset (rst_n=0, immediate): q=RST_VAL, state=IDLE, busy=0, done=0, TC=0, ceo=0.
- Effective modulus M = N, or 2^WIDTH when N=0. Count range 0..M-1. All arithmetic is WIDTH bits, wrapping mod 2^WIDTH.
- Terminal value term:
  - up=1: term = M-1; q >= M-1 is also treated as terminal, so N can shrink below q safely.
  - up=0: term = 0.
- TC = (state==RUN) && terminal condition, evaluated with the current up and N. ceo = TC & ce. Both are 0 in IDLE and DONE.
- FSM states: IDLE, RUN, DONE.
  - IDLE: q holds. start goes to RUN with q = 0 (up) or M-1 (down).
  - RUN, ce=1, not terminal: q increments (up) or decrements (down).
  - RUN, ce=1, terminal, mode=0: q wraps to 0 (up) or M-1 (down); stay in RUN.
  - RUN, ce=1, terminal, mode=1: q holds term; go to DONE.
  - RUN, ce=0: q holds.
  - DONE: q holds; start goes to RUN with the same initial value as from IDLE.
- Start in RUN restarts from the initial value. start and ce in the same cycle: start wins, no count step.
- load (any state, needs no ce): q <= din, state unchanged. Values outside 0..M-1 are accepted; the terminal rules above apply.
- Priority: rst_n > start > load > count step.
- Latency: q updates on the clk edge after the qualifying inputs. TC/ceo follow q and N combinationally with no extra cycle.
- A change of up, N or mode mid-run takes effect from the next evaluated edge; q is not reset.
- busy = (state==RUN); done = (state==DONE); both registered via the state.

Optional Feature:
- Macro MOD_N_COUNTER_SQW_EN.
- Defined: extra output sqw (1 bit, registered, reset 0). sqw toggles on every edge where ceo=1, giving a 50% square wave of period 2·M enabled steps. start clears sqw to 0. load does not affect sqw.
- Undefined: no sqw port and no associated logic. All other behaviour is identical.

Test Plan:
- Periodic count: WIDTH=11, N=20, up=1, mode=0, ce=1, start pulse.
  - q runs 0..19 and wraps to 0.
  - TC=ceo=1 only while q=19, once every 20 cycles; busy=1.
- Gated cascade: ce toggling every cycle, N=20.
  - q advances only on ce=1 edges (one step per 2 clk).
  - ceo high for exactly one clk out of each 40 while q=19.
- One-shot down: N=5, up=0, mode=1, ce=1, start.
  - q = 4,3,2,1,0 with TC at q=0.
  - Next edge: done=1, busy=0, q holds 0, TC=0. A second start restarts at 4.
- Full range: WIDTH=4, N=0, up=1, mode=0.
  - q cycles 0..15; TC at 15; wraps to 0.
- Load/priority: in RUN at q=7 with N=20, assert load with din=18.
  - Next q=18, then 19 (TC), then 0.
  - start and load asserted together: q=0, din ignored.
- Async reset mid-run: drop rst_n between clk edges at q=12.
  - q=0, state IDLE, TC/ceo/busy/done=0 immediately, before the next edge.
  - With MOD_N_COUNTER_SQW_EN defined, sqw=0; for N=3, sqw toggles every 3 ce steps.
